// File: rtl/gpu_sched_pkg.sv
// Shared constants and FSM encoding for the group dispatch path.
package gpu_sched_pkg;
  localparam int NUM_CORES = 16;
  localparam int MSG_W     = 32;
  localparam int LEN_W     = 6;

  localparam logic [1:0] FENCE_NONE  = 2'b00;
  localparam logic [1:0] FENCE_GROUP = 2'b01;
  localparam logic [1:0] FENCE_ALL   = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_STREAM = 2'd2,
    ST_FENCE  = 2'd3
  } state_e;
endpackage

// File: rtl/msg_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a push while full is taken when a pop happens in the same cycle.
module msg_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/core_dispatch.sv
// Admits group headers, broadcasts the group's messages to its cores, and holds
// the next group back until fences and core busy state allow it.
module core_dispatch
  import gpu_sched_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 grp_valid,
  output logic                 grp_ready,
  input  logic [NUM_CORES-1:0] grp_mask,
  input  logic [1:0]           grp_fence,
  input  logic [LEN_W-1:0]     grp_len,
  input  logic [NUM_CORES-1:0] grp_r0,
  input  logic                 msg_valid,
  output logic                 msg_ready,
  input  logic [MSG_W-1:0]     msg_data,
  output logic [NUM_CORES-1:0] core_valid,
  input  logic [NUM_CORES-1:0] core_ready,
  output logic [MSG_W-1:0]     core_msg,
  output logic [NUM_CORES-1:0] core_r0_ld,
  output logic [NUM_CORES-1:0] core_r0,
  input  logic [NUM_CORES-1:0] core_done,
  output logic [NUM_CORES-1:0] exec_mask,
  output logic                 busy
);
  state_e               state_q, state_d;
  logic [NUM_CORES-1:0] mask_q, mask_d, r0_q, r0_d, pend_q, pend_d, exec_mask_q, exec_mask_d;
  logic [1:0]           fence_q, fence_d;
  logic [LEN_W-1:0]     len_q, len_d, rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
  logic                 inflight_q, inflight_d;

  logic                 fifo_full, fifo_empty, push, pop, grp_accept, streaming;
  logic [MSG_W-1:0]     fifo_head;
  logic [NUM_CORES-1:0] offer, left;

  msg_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(MSG_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (msg_data),
    .pop   (pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // First presentation of a head goes to the whole mask; later cycles only to cores still pending.
  always_comb begin
    grp_ready  = (state_q == ST_IDLE) && !rst && ((grp_mask & exec_mask_q) == '0);
    grp_accept = grp_valid && grp_ready;
    streaming  = (state_q == ST_STREAM) && (tx_cnt_q < len_q);
    msg_ready  = (state_q == ST_STREAM) && !fifo_full && (rx_cnt_q < len_q);
    push       = msg_valid && msg_ready;
    offer      = (streaming && !fifo_empty) ? (inflight_q ? pend_q : mask_q) : '0;
    left       = offer & ~core_ready;
    pop        = streaming && !fifo_empty && (left == '0);
    core_valid = offer;
    core_msg   = fifo_empty ? '0 : fifo_head;
    core_r0_ld = (state_q == ST_LOAD) ? mask_q : '0;
    core_r0    = (state_q == ST_LOAD) ? r0_q   : '0;
    exec_mask  = exec_mask_q;
    busy       = (state_q != ST_IDLE) || !fifo_empty;
  end

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    r0_d        = r0_q;
    fence_d     = fence_q;
    len_d       = len_q;
    rx_cnt_d    = rx_cnt_q;
    tx_cnt_d    = tx_cnt_q;
    pend_d      = pend_q;
    inflight_d  = inflight_q;
    exec_mask_d = (exec_mask_q & ~core_done) | (grp_accept ? grp_mask : '0);

    unique case (state_q)
      ST_IDLE: begin
        if (grp_accept) begin
          mask_d     = grp_mask;
          r0_d       = grp_r0;
          fence_d    = grp_fence;
          len_d      = grp_len;
          rx_cnt_d   = '0;
          tx_cnt_d   = '0;
          pend_d     = '0;
          inflight_d = 1'b0;
          state_d    = ST_LOAD;
        end
      end
      ST_LOAD: state_d = (len_q == '0) ? ST_FENCE : ST_STREAM;
      ST_STREAM: begin
        if (push) rx_cnt_d = rx_cnt_q + LEN_W'(1);
        if (pop) begin
          tx_cnt_d   = tx_cnt_q + LEN_W'(1);
          inflight_d = 1'b0;
          pend_d     = '0;
        end else if (offer != '0) begin
          inflight_d = 1'b1;
          pend_d     = left;
        end
        if (tx_cnt_q == len_q) state_d = ST_FENCE;
      end
      ST_FENCE: begin
        unique case (fence_q)
          FENCE_NONE:  state_d = ST_IDLE;
          FENCE_GROUP: if ((exec_mask_q & mask_q) == '0) state_d = ST_IDLE;
          default:     if (exec_mask_q == '0) state_d = ST_IDLE;
        endcase
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mask_q      <= '0;
      r0_q        <= '0;
      fence_q     <= '0;
      len_q       <= '0;
      rx_cnt_q    <= '0;
      tx_cnt_q    <= '0;
      pend_q      <= '0;
      inflight_q  <= 1'b0;
      exec_mask_q <= '0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      r0_q        <= r0_d;
      fence_q     <= fence_d;
      len_q       <= len_d;
      rx_cnt_q    <= rx_cnt_d;
      tx_cnt_q    <= tx_cnt_d;
      pend_q      <= pend_d;
      inflight_q  <= inflight_d;
      exec_mask_q <= exec_mask_d;
    end
  end
endmodule

// File: tb/tb_core_dispatch.sv
// Directed bench for core_dispatch: one task per scenario, expectations hand-computed.
module tb_core_dispatch;
  logic        clk, rst;
  logic        grp_valid, grp_ready;
  logic [15:0] grp_mask, grp_r0;
  logic [1:0]  grp_fence;
  logic [5:0]  grp_len;
  logic        msg_valid, msg_ready;
  logic [31:0] msg_data, core_msg;
  logic [15:0] core_valid, core_ready, core_r0_ld, core_r0, core_done, exec_mask;
  logic        busy;

  int total = 0;
  int bad   = 0;

  core_dispatch #(.FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .grp_valid(grp_valid), .grp_ready(grp_ready), .grp_mask(grp_mask), .grp_fence(grp_fence),
    .grp_len(grp_len), .grp_r0(grp_r0),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_data(msg_data),
    .core_valid(core_valid), .core_ready(core_ready), .core_msg(core_msg),
    .core_r0_ld(core_r0_ld), .core_r0(core_r0), .core_done(core_done),
    .exec_mask(exec_mask), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic hdr(input logic [15:0] m, input logic [1:0] f, input logic [5:0] l, input logic [15:0] r);
    grp_valid = 1'b1; grp_mask = m; grp_fence = f; grp_len = l; grp_r0 = r;
  endtask

  task automatic done_pulse(input logic [15:0] d);
    core_done = d; step(); core_done = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; grp_valid = 0; grp_mask = 0; grp_fence = 0; grp_len = 0; grp_r0 = 0;
    msg_valid = 0; msg_data = 0; core_ready = '1; core_done = 0;
    step(2);
    if (grp_ready !== 1'b0)   begin $display("FAIL rst_grp_ready got=%h exp=0", grp_ready); bad++; end total++;
    if (exec_mask !== 16'h0)  begin $display("FAIL rst_exec got=%h exp=0", exec_mask); bad++; end total++;
    if (core_valid !== 16'h0) begin $display("FAIL rst_core_valid got=%h exp=0", core_valid); bad++; end total++;
    if (core_r0_ld !== 16'h0) begin $display("FAIL rst_r0_ld got=%h exp=0", core_r0_ld); bad++; end total++;
    if (busy !== 1'b0)        begin $display("FAIL rst_busy got=%h exp=0", busy); bad++; end total++;
    rst = 1'b0;
    step();
    if (grp_ready !== 1'b1)   begin $display("FAIL idle_grp_ready got=%h exp=1", grp_ready); bad++; end total++;
  endtask

  task automatic test_basic();
    hdr(16'h0003, 2'b00, 6'd2, 16'h0001);
    if (grp_ready !== 1'b1) begin $display("FAIL t1_accept got=%h exp=1", grp_ready); bad++; end total++;
    step();
    grp_valid = 0;
    if (core_r0_ld !== 16'h0003) begin $display("FAIL t1_r0_ld got=%h exp=0003", core_r0_ld); bad++; end total++;
    if (core_r0 !== 16'h0001)    begin $display("FAIL t1_r0 got=%h exp=0001", core_r0); bad++; end total++;
    if (exec_mask !== 16'h0003)  begin $display("FAIL t1_exec got=%h exp=0003", exec_mask); bad++; end total++;
    msg_valid = 1; msg_data = 32'h1111_0000;
    step();
    if (core_r0_ld !== 16'h0) begin $display("FAIL t1_r0_ld_pulse got=%h exp=0", core_r0_ld); bad++; end total++;
    if (msg_ready !== 1'b1)   begin $display("FAIL t1_msg_ready got=%h exp=1", msg_ready); bad++; end total++;
    step();
    if (core_valid !== 16'h0003)   begin $display("FAIL t1_bc0_valid got=%h exp=0003", core_valid); bad++; end total++;
    if (core_msg !== 32'h1111_0000) begin $display("FAIL t1_bc0_msg got=%h exp=11110000", core_msg); bad++; end total++;
    msg_data = 32'h1111_0001;
    step();
    if (core_valid !== 16'h0003)   begin $display("FAIL t1_bc1_valid got=%h exp=0003", core_valid); bad++; end total++;
    if (core_msg !== 32'h1111_0001) begin $display("FAIL t1_bc1_msg got=%h exp=11110001", core_msg); bad++; end total++;
    if (msg_ready !== 1'b0)        begin $display("FAIL t1_len_limit got=%h exp=0", msg_ready); bad++; end total++;
    msg_valid = 0;
    step();
    if (core_valid !== 16'h0) begin $display("FAIL t1_no_extra got=%h exp=0", core_valid); bad++; end total++;
    step(2);
    if (busy !== 1'b0)          begin $display("FAIL t1_idle got=%h exp=0", busy); bad++; end total++;
    if (exec_mask !== 16'h0003) begin $display("FAIL t1_exec_hold got=%h exp=0003", exec_mask); bad++; end total++;
    if (grp_ready !== 1'b0)     begin $display("FAIL t1_overlap got=%h exp=0", grp_ready); bad++; end total++;
    done_pulse(16'h0003);
    if (exec_mask !== 16'h0) begin $display("FAIL t1_done got=%h exp=0", exec_mask); bad++; end total++;
  endtask

  task automatic test_stall();
    hdr(16'h0003, 2'b00, 6'd2, 16'h0002);
    step(); grp_valid = 0;
    msg_valid = 1; msg_data = 32'h2222_0000;
    step(); core_ready = 16'h0001;
    step();
    if (core_valid !== 16'h0003) begin $display("FAIL t2_first got=%h exp=0003", core_valid); bad++; end total++;
    msg_data = 32'h2222_0001;
    for (int i = 0; i < 3; i++) begin
      step();
      if (i == 0) msg_valid = 0;
      if (i == 2) core_ready = '1;
      if (core_valid !== 16'h0002)   begin $display("FAIL t2_hold%0d got=%h exp=0002", i, core_valid); bad++; end total++;
      if (core_msg !== 32'h2222_0000) begin $display("FAIL t2_msg%0d got=%h exp=22220000", i, core_msg); bad++; end total++;
    end
    step();
    if (core_valid !== 16'h0003)   begin $display("FAIL t2_next_valid got=%h exp=0003", core_valid); bad++; end total++;
    if (core_msg !== 32'h2222_0001) begin $display("FAIL t2_next_msg got=%h exp=22220001", core_msg); bad++; end total++;
    step(3);
    done_pulse(16'h0003);
  endtask

  task automatic test_overlap();
    hdr(16'h00F0, 2'b00, 6'd0, 16'h0);
    step(); grp_valid = 0;
    step(2);
    hdr(16'h0030, 2'b00, 6'd0, 16'h0);
    step();
    if (grp_ready !== 1'b0) begin $display("FAIL t3_block0 got=%h exp=0", grp_ready); bad++; end total++;
    done_pulse(16'h0010);
    if (exec_mask !== 16'h00E0) begin $display("FAIL t3_exec got=%h exp=00e0", exec_mask); bad++; end total++;
    if (grp_ready !== 1'b0)     begin $display("FAIL t3_block1 got=%h exp=0", grp_ready); bad++; end total++;
    done_pulse(16'h0020);
    if (grp_ready !== 1'b1) begin $display("FAIL t3_admit got=%h exp=1", grp_ready); bad++; end total++;
    step(); grp_valid = 0;
    if (exec_mask !== 16'h00F0)  begin $display("FAIL t3_exec_set got=%h exp=00f0", exec_mask); bad++; end total++;
    if (core_r0_ld !== 16'h0030) begin $display("FAIL t3_r0_ld got=%h exp=0030", core_r0_ld); bad++; end total++;
    step(2);
    done_pulse(16'h00F0);
  endtask

  task automatic test_fence_all();
    hdr(16'h0020, 2'b00, 6'd0, 16'h0);
    step(); grp_valid = 0;
    step(2);
    hdr(16'h0001, 2'b10, 6'd1, 16'h0001);
    step(); grp_valid = 0; grp_mask = 16'h0100;
    msg_valid = 1; msg_data = 32'h4444_0000;
    step(2); msg_valid = 0;
    step(3);
    if (busy !== 1'b1)      begin $display("FAIL t4_fence_busy got=%h exp=1", busy); bad++; end total++;
    if (grp_ready !== 1'b0) begin $display("FAIL t4_fence_rdy got=%h exp=0", grp_ready); bad++; end total++;
    done_pulse(16'h0020);
    if (exec_mask !== 16'h0001) begin $display("FAIL t4_exec got=%h exp=0001", exec_mask); bad++; end total++;
    if (grp_ready !== 1'b0)     begin $display("FAIL t4_still got=%h exp=0", grp_ready); bad++; end total++;
    done_pulse(16'h0001);
    if (busy !== 1'b1)      begin $display("FAIL t4_last_busy got=%h exp=1", busy); bad++; end total++;
    if (grp_ready !== 1'b0) begin $display("FAIL t4_last_rdy got=%h exp=0", grp_ready); bad++; end total++;
    step();
    if (grp_ready !== 1'b1) begin $display("FAIL t4_release got=%h exp=1", grp_ready); bad++; end total++;
    if (busy !== 1'b0)      begin $display("FAIL t4_idle got=%h exp=0", busy); bad++; end total++;
  endtask

  task automatic test_fifo_full();
    int acc = 0;
    int popcnt = 0;
    logic rdy;
    core_ready = '0;
    hdr(16'h0001, 2'b00, 6'd12, 16'h0);
    step(); grp_valid = 0;
    msg_valid = 1; msg_data = 32'hA000_0000;
    step();
    for (int k = 0; k < 40; k++) begin
      if (k == 12) begin
        if (acc !== 8)          begin $display("FAIL t5_acc8 got=%0d exp=8", acc); bad++; end total++;
        if (msg_ready !== 1'b0) begin $display("FAIL t5_full got=%h exp=0", msg_ready); bad++; end total++;
        core_ready = '1;
      end
      if (core_valid[0] && core_ready[0]) begin
        if (core_msg !== 32'hA000_0000 + popcnt) begin
          $display("FAIL t5_order%0d got=%h exp=%h", popcnt, core_msg, 32'hA000_0000 + popcnt); bad++;
        end
        total++;
        popcnt++;
      end
      rdy = msg_valid && msg_ready;
      step();
      if (rdy) begin acc++; msg_data = 32'hA000_0000 + acc; end
    end
    msg_valid = 0;
    if (acc !== 12)    begin $display("FAIL t5_acc got=%0d exp=12", acc); bad++; end total++;
    if (popcnt !== 12) begin $display("FAIL t5_pops got=%0d exp=12", popcnt); bad++; end total++;
    if (busy !== 1'b0) begin $display("FAIL t5_idle got=%h exp=0", busy); bad++; end total++;
    done_pulse(16'h0001);
  endtask

  task automatic test_mid_reset();
    core_ready = '0;
    hdr(16'h0003, 2'b00, 6'd4, 16'h0003);
    step(); grp_valid = 0;
    msg_valid = 1; msg_data = 32'h6666_0000;
    step(3);
    msg_valid = 0; rst = 1'b1;
    step();
    if (grp_ready !== 1'b0)    begin $display("FAIL t6_grp_ready got=%h exp=0", grp_ready); bad++; end total++;
    if (msg_ready !== 1'b0)    begin $display("FAIL t6_msg_ready got=%h exp=0", msg_ready); bad++; end total++;
    if (core_valid !== 16'h0)  begin $display("FAIL t6_valid got=%h exp=0", core_valid); bad++; end total++;
    if (exec_mask !== 16'h0)   begin $display("FAIL t6_exec got=%h exp=0", exec_mask); bad++; end total++;
    if (busy !== 1'b0)         begin $display("FAIL t6_busy got=%h exp=0", busy); bad++; end total++;
    if (core_msg !== 32'h0)    begin $display("FAIL t6_msg got=%h exp=0", core_msg); bad++; end total++;
    rst = 1'b0; core_ready = '1;
    step();
    hdr(16'h0003, 2'b00, 6'd1, 16'h0002);
    if (grp_ready !== 1'b1) begin $display("FAIL t6_readmit got=%h exp=1", grp_ready); bad++; end total++;
    step(); grp_valid = 0;
    if (core_r0_ld !== 16'h0003) begin $display("FAIL t6_r0_ld got=%h exp=0003", core_r0_ld); bad++; end total++;
    msg_valid = 1; msg_data = 32'h7777_0000;
    step(2); msg_valid = 0;
    if (core_valid !== 16'h0003)   begin $display("FAIL t6_bc_valid got=%h exp=0003", core_valid); bad++; end total++;
    if (core_msg !== 32'h7777_0000) begin $display("FAIL t6_bc_msg got=%h exp=77770000", core_msg); bad++; end total++;
    step(3);
    done_pulse(16'h0003);
    if (exec_mask !== 16'h0) begin $display("FAIL t6_done got=%h exp=0", exec_mask); bad++; end total++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_overlap();
    test_fence_all();
    test_fifo_full();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
